dsa_pixel_fetch: RTL

Fetch responder for the sequential bilinear DSA. It answers the control FSM's `fetch_req`/`fetch_done` handshake. For each output coordinate it computes the fixed-point source coordinate, clamps the 2×2 neighbourhood to the input image, reads the four neighbour pixels from the synchronous source-image RAM, and presents them with the fractional weights to the interpolation datapath. It sits between the control FSM, the source RAM port and the datapath.

---
 rtl/dsa_pixel_fetch.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/dsa_pixel_fetch.sv
`default_nettype none
// ============================================================================
// Module   : dsa_pixel_fetch
// Brief    : Fetch responder for the sequential bilinear DSA. Maps one output
//            coordinate to a Q8.8 source position, clamps the 2x2
//            neighbourhood to the image, reads the four neighbours from the
//            synchronous source RAM and presents them with their weights.
// Revision : 1.0 - initial release
// ============================================================================
module dsa_pixel_fetch #(
  parameter int IMG_WIDTH_MAX  = 512,
  parameter int IMG_HEIGHT_MAX = 512,
  parameter int ADDR_WIDTH     = 18
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_req,
  output logic                  fetch_done,
  input  logic [15:0]           dst_x,
  input  logic [15:0]           dst_y,
  input  logic [15:0]           img_width_in,
  input  logic [15:0]           img_height_in,
  input  logic [15:0]           scale_step,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [7:0]            mem_rdata,
  output logic [7:0]            p00,
  output logic [7:0]            p01,
  output logic [7:0]            p10,
  output logic [7:0]            p11,
  output logic [7:0]            frac_x,
  output logic [7:0]            frac_y,
  output logic                  busy
);

  // Sizes above the configured maximum are saturated to it; within range the
  // size is used exactly as supplied.
  localparam logic [15:0] c_W_MAX = 16'(IMG_WIDTH_MAX);
  localparam logic [15:0] c_H_MAX = 16'(IMG_HEIGHT_MAX);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CALC  = 3'd1,
    S_ADDR0 = 3'd2,
    S_ADDR1 = 3'd3,
    S_ADDR2 = 3'd4,
    S_ADDR3 = 3'd5,
    S_CAPT  = 3'd6,
    S_DONE  = 3'd7
  } state_t;

  state_t r_state;
  state_t w_next;

  // Request fields, frozen for the whole transaction
  logic [15:0] r_dst_x;
  logic [15:0] r_dst_y;
  logic [15:0] r_w;
  logic [15:0] r_h;
  logic [15:0] r_step;

  // Registered outputs
  logic                  r_mem_rd;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic                  r_done;
  logic                  r_busy;
  logic [7:0]            r_p00;
  logic [7:0]            r_p01;
  logic [7:0]            r_p10;
  logic [7:0]            r_p11;
  logic [7:0]            r_frac_x;
  logic [7:0]            r_frac_y;

  // Staging for the first three read returns; the fourth goes straight to p11
  logic [7:0] r_s00;
  logic [7:0] r_s01;
  logic [7:0] r_s10;

  // Coordinate mapping (settles during CALC from the frozen request fields)
  logic [31:0]           w_sx;
  logic [31:0]           w_sy;
  logic [23:0]           w_ix;
  logic [23:0]           w_iy;
  logic [15:0]           w_wm;
  logic [15:0]           w_hm;
  logic                  w_x_edge;
  logic                  w_y_edge;
  logic [15:0]           w_x0;
  logic [15:0]           w_x1;
  logic [15:0]           w_y0;
  logic [15:0]           w_y1;
  logic [7:0]            w_fx;
  logic [7:0]            w_fy;
  logic [ADDR_WIDTH-1:0] w_a00;
  logic [ADDR_WIDTH-1:0] w_a01;
  logic [ADDR_WIDTH-1:0] w_a10;
  logic [ADDR_WIDTH-1:0] w_a11;
  logic                  w_rd_next;
  logic [ADDR_WIDTH-1:0] w_addr_next;

  // Linear address y*W + x, formed in 32 bits then truncated to the RAM width
  function automatic logic [ADDR_WIDTH-1:0] f_addr(input logic [15:0] y,
                                                   input logic [15:0] x,
                                                   input logic [15:0] w);
    logic [31:0] full;
    full = ({16'd0, y} * {16'd0, w}) + {16'd0, x};
    return ADDR_WIDTH'(full);
  endfunction

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic: a fixed walk once a request is accepted in IDLE
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (fetch_req) w_next = S_CALC;
      S_CALC:  w_next = S_ADDR0;
      S_ADDR0: w_next = S_ADDR1;
      S_ADDR1: w_next = S_ADDR2;
      S_ADDR2: w_next = S_ADDR3;
      S_ADDR3: w_next = S_CAPT;
      S_CAPT:  w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Latch the request fields on acceptance only
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dst_x <= 16'd0;
      r_dst_y <= 16'd0;
      r_w     <= 16'd0;
      r_h     <= 16'd0;
      r_step  <= 16'd0;
    end else if (r_state == S_IDLE && fetch_req) begin
      r_dst_x <= dst_x;
      r_dst_y <= dst_y;
      r_w     <= (img_width_in  > c_W_MAX) ? c_W_MAX : img_width_in;
      r_h     <= (img_height_in > c_H_MAX) ? c_H_MAX : img_height_in;
      r_step  <= scale_step;
    end
  end

  // Source position, clamped neighbourhood, edge-forced weights, addresses
  always_comb begin
    w_sx = {16'd0, r_dst_x} * {16'd0, r_step};
    w_sy = {16'd0, r_dst_y} * {16'd0, r_step};
    w_ix = w_sx[31:8];
    w_iy = w_sy[31:8];
    // A zero dimension behaves as a dimension of one
    w_wm = (r_w == 16'd0) ? 16'd0 : r_w - 16'd1;
    w_hm = (r_h == 16'd0) ? 16'd0 : r_h - 16'd1;
    w_x_edge = (w_ix >= {8'd0, w_wm});
    w_y_edge = (w_iy >= {8'd0, w_hm});
    w_x0 = w_x_edge ? w_wm : w_ix[15:0];
    w_y0 = w_y_edge ? w_hm : w_iy[15:0];
    w_x1 = (w_x0 >= w_wm) ? w_wm : w_x0 + 16'd1;
    w_y1 = (w_y0 >= w_hm) ? w_hm : w_y0 + 16'd1;
    // At the right/bottom edge the neighbour pair collapses, so weight is 0
    w_fx = w_x_edge ? 8'd0 : w_sx[7:0];
    w_fy = w_y_edge ? 8'd0 : w_sy[7:0];
    w_a00 = f_addr(w_y0, w_x0, r_w);
    w_a01 = f_addr(w_y0, w_x1, r_w);
    w_a10 = f_addr(w_y1, w_x0, r_w);
    w_a11 = f_addr(w_y1, w_x1, r_w);
  end

  // Read strobe/address for the upcoming state; address holds when idle
  always_comb begin
    w_rd_next   = 1'b0;
    w_addr_next = r_mem_addr;
    case (w_next)
      S_ADDR0: begin w_rd_next = 1'b1; w_addr_next = w_a00; end
      S_ADDR1: begin w_rd_next = 1'b1; w_addr_next = w_a01; end
      S_ADDR2: begin w_rd_next = 1'b1; w_addr_next = w_a10; end
      S_ADDR3: begin w_rd_next = 1'b1; w_addr_next = w_a11; end
      default: ;
    endcase
  end

  // Registered control outputs, aligned with the state they belong to
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_rd   <= 1'b0;
      r_mem_addr <= '0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_mem_rd   <= w_rd_next;
      r_mem_addr <= w_addr_next;
      r_done     <= (w_next == S_DONE);
      r_busy     <= (w_next != S_IDLE);
    end
  end

  // Capture read returns one cycle after each strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s00 <= 8'd0;
      r_s01 <= 8'd0;
      r_s10 <= 8'd0;
    end else begin
      case (r_state)
        S_ADDR1: r_s00 <= mem_rdata;
        S_ADDR2: r_s01 <= mem_rdata;
        S_ADDR3: r_s10 <= mem_rdata;
        default: ;
      endcase
    end
  end

  // Publish neighbours and weights together on the edge leaving CAPT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p00    <= 8'd0;
      r_p01    <= 8'd0;
      r_p10    <= 8'd0;
      r_p11    <= 8'd0;
      r_frac_x <= 8'd0;
      r_frac_y <= 8'd0;
    end else if (r_state == S_CAPT) begin
      r_p00    <= r_s00;
      r_p01    <= r_s01;
      r_p10    <= r_s10;
      r_p11    <= mem_rdata;
      r_frac_x <= w_fx;
      r_frac_y <= w_fy;
    end
  end

  assign mem_rd     = r_mem_rd;
  assign mem_addr   = r_mem_addr;
  assign fetch_done = r_done;
  assign busy       = r_busy;
  assign p00        = r_p00;
  assign p01        = r_p01;
  assign p10        = r_p10;
  assign p11        = r_p11;
  assign frac_x     = r_frac_x;
  assign frac_y     = r_frac_y;

endmodule
`default_nettype wire
